// File: rtl/control_pkg.sv
// Shared encodings for the five-FIFO control path: one-hot states, FIFO count and threshold defaults.
// Pure declarations; no latency or backpressure of its own.
package control_pkg;

  localparam int N_FIFOS         = 5;
  localparam int UMBRAL_W        = 3;
  localparam int UMBRAL_ALTO_RST = 6;
  localparam int UMBRAL_BAJO_RST = 1;

  localparam logic [4:0] S_RESET  = 5'b00001;
  localparam logic [4:0] S_INIT   = 5'b00010;
  localparam logic [4:0] S_IDLE   = 5'b00100;
  localparam logic [4:0] S_ACTIVE = 5'b01000;
  localparam logic [4:0] S_ERROR  = 5'b10000;

  typedef enum logic [4:0] {
    ST_RESET  = S_RESET,
    ST_INIT   = S_INIT,
    ST_IDLE   = S_IDLE,
    ST_ACTIVE = S_ACTIVE,
    ST_ERROR  = S_ERROR
  } state_t;

endpackage

// File: rtl/umbral_regs.sv
// Almost-full/almost-empty threshold registers with reset defaults and a bajo<alto validity flag.
// Loads one cycle after load_en is sampled; no backpressure, umbral_ok is combinational on the registers.
module umbral_regs #(
  parameter int UMBRAL_W        = 3,
  parameter int UMBRAL_ALTO_RST = 6,
  parameter int UMBRAL_BAJO_RST = 1
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                load_en,
  input  logic [UMBRAL_W-1:0] umbral_alto_in,
  input  logic [UMBRAL_W-1:0] umbral_bajo_in,
  output logic [UMBRAL_W-1:0] umbral_alto,
  output logic [UMBRAL_W-1:0] umbral_bajo,
  output logic                umbral_ok
);

  logic [UMBRAL_W-1:0] alto_q;
  logic [UMBRAL_W-1:0] bajo_q;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      alto_q <= UMBRAL_W'(UMBRAL_ALTO_RST);
      bajo_q <= UMBRAL_W'(UMBRAL_BAJO_RST);
    end else if (load_en) begin
      alto_q <= umbral_alto_in;
      bajo_q <= umbral_bajo_in;
    end
  end

  assign umbral_alto = alto_q;
  assign umbral_bajo = bajo_q;
  assign umbral_ok   = (bajo_q < alto_q);

endmodule

// File: rtl/control_fsm.sv
// Main control FSM for the five-FIFO datapath: reset/init/idle/active sequencing and sticky error capture.
// Moore outputs, one cycle after inputs are sampled; no backpressure, inputs are qualifiers only.
module control_fsm #(
  parameter int N_FIFOS         = control_pkg::N_FIFOS,
  parameter int UMBRAL_W        = control_pkg::UMBRAL_W,
  parameter int UMBRAL_ALTO_RST = control_pkg::UMBRAL_ALTO_RST,
  parameter int UMBRAL_BAJO_RST = control_pkg::UMBRAL_BAJO_RST
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                init,
  input  logic [UMBRAL_W-1:0] umbral_alto_in,
  input  logic [UMBRAL_W-1:0] umbral_bajo_in,
  input  logic [N_FIFOS-1:0]  fifo_empty,
  input  logic [N_FIFOS-1:0]  fifo_error,
  output logic [4:0]          state,
  output logic                idle,
  output logic                active,
  output logic                error_out,
  output logic [N_FIFOS-1:0]  error_id,
  output logic [UMBRAL_W-1:0] umbral_alto,
  output logic [UMBRAL_W-1:0] umbral_bajo
);

  import control_pkg::*;

  state_t             state_q;
  state_t             state_d;
  logic [N_FIFOS-1:0] error_id_q;
  logic               umbral_ok;
  logic               load_en;
  logic               all_empty;
  logic               any_error;

  assign all_empty = &fifo_empty;
  assign any_error = |fifo_error;
  assign load_en   = (state_q == ST_INIT) && init;

  umbral_regs #(
    .UMBRAL_W        (UMBRAL_W),
    .UMBRAL_ALTO_RST (UMBRAL_ALTO_RST),
    .UMBRAL_BAJO_RST (UMBRAL_BAJO_RST)
  ) u_umbral_regs (
    .clk            (clk),
    .reset_L        (reset_L),
    .load_en        (load_en),
    .umbral_alto_in (umbral_alto_in),
    .umbral_bajo_in (umbral_bajo_in),
    .umbral_alto    (umbral_alto),
    .umbral_bajo    (umbral_bajo),
    .umbral_ok      (umbral_ok)
  );

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q    <= ST_RESET;
      error_id_q <= '0;
    end else begin
      state_q <= state_d;
      // Snapshot only on entry; bad thresholds out of INIT record no FIFO.
      if (state_q != ST_ERROR && state_d == ST_ERROR)
        error_id_q <= (state_q == ST_INIT) ? '0 : fifo_error;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT: begin
        if (!init)
          state_d = umbral_ok ? ST_IDLE : ST_ERROR;
      end
      ST_IDLE: begin
        if (any_error)       state_d = ST_ERROR;
        else if (init)       state_d = ST_INIT;
        else if (!all_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (any_error)       state_d = ST_ERROR;
        else if (init)       state_d = ST_INIT;
        else if (all_empty)  state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
  end

  assign state     = state_q;
  assign idle      = (state_q == ST_IDLE);
  assign active    = (state_q == ST_ACTIVE);
  assign error_out = (state_q == ST_ERROR);
  assign error_id  = error_id_q;

endmodule

// File: doc/control_fsm.md
# control_fsm

Main control state machine for the five-FIFO datapath; it sits directly upstream of the pop counter block and produces the `idle` qualifier that the counter uses to report its totals. It sequences reset, threshold initialisation, idle and active operation, and latches a sticky error when any FIFO reports overflow or underflow. It also holds the programmed almost-full/almost-empty thresholds and distributes them to the FIFOs.

## Interface
Parameters:
- `N_FIFOS`, 5: number of supervised FIFOs.
- `UMBRAL_W`, 3: threshold width; FIFO depth is 2^UMBRAL_W.
- `UMBRAL_ALTO_RST`, 6: almost-full threshold loaded at reset.
- `UMBRAL_BAJO_RST`, 1: almost-empty threshold loaded at reset.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset_L`  in  1  synchronous, active-low reset.
- `init`  in  1  request to (re)enter the INIT state and load thresholds.
- `umbral_alto_in`  in  UMBRAL_W  almost-full threshold to load.
- `umbral_bajo_in`  in  UMBRAL_W  almost-empty threshold to load.
- `fifo_empty`  in  N_FIFOS  per-FIFO empty flags.
- `fifo_error`  in  N_FIFOS  per-FIFO error flags (push when full or pop when empty).
- `state`  out  5  one-hot state: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.
- `idle`  out  1  high exactly while state is IDLE.
- `active`  out  1  high exactly while state is ACTIVE.
- `error_out`  out  1  high exactly while state is ERROR.
- `error_id`  out  N_FIFOS  snapshot of `fifo_error` taken when ERROR is entered.
- `umbral_alto`  out  UMBRAL_W  current almost-full threshold.
- `umbral_bajo`  out  UMBRAL_W  current almost-empty threshold.

## Operation
- Moore machine. All outputs decode from registered state and registers only; no input-to-output combinational path.
- Priority in IDLE and ACTIVE is: any `fifo_error` bit first, then `init`, then the empty condition.
- Transitions:
  - RESET: goes to INIT on the first edge with `reset_L`=1.
  - INIT, `init`=1: stays in INIT and loads both thresholds from the inputs on every edge.
  - INIT, `init`=0: goes to IDLE, provided the loaded thresholds are valid.
  - IDLE: goes to ACTIVE when `fifo_empty` is not all ones.
  - ACTIVE: goes to IDLE when `fifo_empty` is all ones.
  - ERROR: stays there. Only `reset_L`=0 leaves it; `init` is ignored.
- Threshold validity:
  - Thresholds are valid only when `umbral_bajo` < `umbral_alto`, compared unsigned.
  - If INIT exits with invalid thresholds, the next state is ERROR and `error_id` is set to all zeros.
  - The invalid thresholds are still visible on the outputs.
- `error_id`:
  - Loaded with `fifo_error` on the edge that enters ERROR.
  - Holds that value until reset.
  - Later error bits are not ORed in.
- Thresholds hold their values in every state other than INIT.

## Timing
- Reset: on any edge with `reset_L`=0, regardless of the current state, the block takes these values:
  - `state`=RESET, `idle`=`active`=`error_out`=0, `error_id`=0.
  - `umbral_alto`=UMBRAL_ALTO_RST, `umbral_bajo`=UMBRAL_BAJO_RST.
- Reset asserted mid-operation, including from ERROR, takes effect at the next edge.
- Latency: inputs are sampled at edge k. The state and outputs change after edge k and are visible during cycle k+1.
- Minimum path from reset release to IDLE:
  - Edge 1 goes to INIT.
  - Edge 2 goes to IDLE if `init`=0.
  - `idle` is high from cycle 3.
- Thresholds loaded at the last INIT edge with `init`=1 are the ones kept.
- If `init` is low on the first INIT cycle, the reset defaults are kept. They are valid, so the block goes to IDLE.
- If `fifo_error` and `init` are asserted on the same edge in IDLE or ACTIVE, the next state is ERROR.
- If every FIFO empties on the same edge as `init`, the next state is INIT.
- A `fifo_error` pulse lasting one cycle is sufficient to enter ERROR.

## Structure
- Shared package (`control_pkg`) holds:
  - the one-hot state localparams;
  - N_FIFOS;
  - the reset threshold defaults.
- The pop counter imports the same IDLE encoding from this package.
- One sub-module, `umbral_regs`, holds:
  - the threshold registers;
  - their reset values;
  - the INIT load enable;
  - a `umbral_ok` output that is the `bajo < alto` compare.
- The FSM, the output decode and the `error_id` register stay in `control_fsm`.

## Test plan
- Reset and defaults:
  - Stimulus: `reset_L`=0 for 2 edges, then 1, with `init`=0 and `fifo_empty`=11111.
  - Required: `state` = 00001 → 00010 → 00100; `idle`=1 from the 3rd cycle after release; thresholds 6/1.
- Threshold load:
  - Stimulus: `init`=1 for 3 edges with alto=5, bajo=2, then `init`=0.
  - Required: outputs read 5/2 and the block goes to IDLE; a later change to the inputs does not change the outputs.
- Invalid thresholds:
  - Stimulus: load alto=2, bajo=2 in INIT.
  - Required: next state ERROR (10000), `error_out`=1, `error_id`=00000.
- Idle and active cycling:
  - Stimulus: from IDLE set `fifo_empty`=11110, then 11111.
  - Required: ACTIVE the cycle after the first edge (`idle`=0, `active`=1), then back to IDLE with `idle`=1.
- Sticky error:
  - Stimulus: in ACTIVE, pulse `fifo_error`=00100 for 1 cycle at the same time as `init`=1, then assert `init` again.
  - Required: ERROR is entered, `error_id`=00100, and the state stays ERROR.
  - Then `reset_L`=0 for 1 edge: state returns to RESET with `error_id`=0.
- Re-init from ACTIVE:
  - Stimulus: `init`=1 while `fifo_empty`=00000.
  - Required: INIT on the next cycle and thresholds reload.
  - After `init` drops: IDLE, and then ACTIVE one cycle later.
